ro_wr_sched: RTL and testbench
==============================

// Module: ro_wr_sched
// PURPOSE
// - Write scheduler between the reorder stage and the DDR write DataMover (S2MM). Slices the reorder output
//   stream (8 ch/beat) into per-(tile,line,ch-group) segments of img_w beats, issues one command per segment
//   with its DDR address, then forwards that segment's beats with tlast. Counts write statuses; signals done/err.
// PARAMETERS
// - DW      16  bits per channel (DATA_INTER_WIDTH); beat = 8*DW bits, BEAT_BYTES = DW
// - ADDR_W  32  DDR byte-address width
// - BTT_W   23  bytes-to-transfer field width
// PORTS
// - clk            in   1        clock
// - rst_n          in   1        asynchronous, active-low reset
// - s_config_valid in   1        config word valid
// - s_config_ready out  1        config word accepted when valid&ready
// - s_config_data  in   32       w0=base_addr; w1={w_tile[7:0],img_h[11:0],img_w[11:0]}; w2={ch_total,ch_perwtile}
// - ro_data        in   8*DW     reorder output beat
// - ro_valid       in   1        reorder beat valid
// - ro_ready       out  1        beat consumed
// - m_axis_tdata   out  8*DW     write data to DataMover
// - m_axis_tvalid  out  1        write data valid
// - m_axis_tready  in   1        DataMover data ready
// - m_axis_tlast   out  1        last beat of current segment
// - m_cmd_valid    out  1        command valid
// - m_cmd_ready    in   1        command accepted
// - m_cmd_addr     out  ADDR_W   segment start byte address
// - m_cmd_btt      out  BTT_W    segment length in bytes = img_w*BEAT_BYTES
// - s_sts_valid    in   1        one write status per segment (always accepted)
// - s_sts_okay     in   1        status OK (0 = DDR error)
// - done           out  1        one-cycle pulse: job complete, all statuses received
// - err            out  1        sticky: bad config or status error; cleared by next accepted w0
// - status_wr      out  4        current FSM state code
// BEHAVIOUR
// - Reset: state IDLE; s_config_ready=1; m_cmd_valid=0; m_axis_tvalid=0; ro_ready=0; done=0; err=0; all counters 0.
// - FSM: IDLE(0) -> CFG words 0..2 accepted in order -> PRE(1) -> CMD(2) <-> DATA(3) -> DRAIN(4) -> IDLE.
// - IDLE: s_config_ready=1; word index advances on each handshake; third handshake -> PRE, ready drops next cycle.
// - PRE (1 cycle): seg_bytes=img_w*DW; ngrp=ceil(ch_perwtile/8); line_stride=ceil(ch_total/8)*seg_bytes;
//   tile_stride=ngrp*seg_bytes. img_w==0, img_h==0, w_tile==0 or ch_perwtile==0 -> err=1, IDLE, no command.
//   img_h is the line count the reorder stage emits (already includes any extra line); used unchanged.
// - Loop order (outer->inner): tile t<w_tile, line l<img_h, group g<ngrp, pix p<img_w; matches reorder output.
// - Address: base + t*tile_stride + l*line_stride + g*seg_bytes, held incrementally in tile/line/seg regs
//   (adds only, no multiplier outside PRE); wraps modulo 2^ADDR_W, no error.
// - CMD: m_cmd_valid=1, addr/btt stable until m_cmd_ready; on handshake -> DATA same edge. One command outstanding.
// - DATA: zero-latency pass-through: m_axis_tvalid=ro_valid, ro_ready=m_axis_tready, tdata=ro_data;
//   m_axis_tlast=(p==img_w-1). Beat counts on ro_valid&m_axis_tready. Last beat: advance g/l/t; final segment
//   -> DRAIN, else CMD. ro_ready=0 and tvalid=0 outside DATA (reorder back-pressured, never dropped).
// - Status: sts_cnt increments on s_sts_valid in any non-IDLE state; !s_sts_okay sets err (job continues).
//   DRAIN waits sts_cnt==w_tile*img_h*ngrp, then done=1 one cycle, -> IDLE. Status arriving in same cycle as
//   final beat is counted.
// - Reset asserted mid-job: immediate return to reset values; partial DataMover transfer is not resumed.
// STRUCTURE
// - Shared package/header: state codes, config word bit-field positions, BEAT_BYTES derivation.
// - One sub-module natural: ro_seg_addr_gen (t/l/g/p counters + incremental address regs, advance/last outputs).
// - Top: config capture, FSM, handshake muxing, status counter.
// TESTING
// - Config base=0x1000_0000, img_w=4, img_h=2, w_tile=1, ch_perwtile=ch_total=16, DW=16, always-ready sinks
//   -> 4 cmds addr 0x1000_0000/0040/0080/00C0, btt=64, 16 beats, tlast every 4th, done after 4 statuses.
// - Same with w_tile=2, ch_perwtile=16, ch_total=32 -> tile1 line0 first cmd addr base+0x80, line stride 0x100.
// - m_cmd_ready held 0 for 10 cycles -> addr stable, ro_ready=0, no beats forwarded, no loss afterwards.
// - Random m_axis_tready/ro_valid toggling -> output beats equal input sequence, tlast positions unchanged.
// - img_w=0 config -> err=1, no m_cmd_valid, back to IDLE; next valid config clears err and runs.
// - s_sts_okay=0 on 2nd status -> err=1 sticky, done still pulses after last status; rst_n low mid-DATA -> all outputs reset.

Source files
------------

// File: rtl/ro_wr_sched_pkg.sv
// ro_wr_sched_pkg: definitions shared by the reorder write scheduler and its
// segment address generator.
//   - wr_state_e : FSM state codes, also driven out on status_wr
//   - config word bit-field positions (words w1 and w2)
//   - beat_bytes()  : bytes carried by one 8-channel beat
//   - ceil_groups() : number of 8-channel groups needed for a channel count
package ro_wr_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PRE   = 4'd1,
    ST_CMD   = 4'd2,
    ST_DATA  = 4'd3,
    ST_DRAIN = 4'd4
  } wr_state_e;

  // w1 = {w_tile[7:0], img_h[11:0], img_w[11:0]}
  localparam int IMG_W_LSB   = 0;
  localparam int IMG_W_BITS  = 12;
  localparam int IMG_H_LSB   = 12;
  localparam int IMG_H_BITS  = 12;
  localparam int W_TILE_LSB  = 24;
  localparam int W_TILE_BITS = 8;

  // w2 = {ch_total[15:0], ch_perwtile[15:0]}
  localparam int CH_PER_LSB  = 0;
  localparam int CH_TOT_LSB  = 16;
  localparam int CH_BITS     = 16;

  localparam int CH_PER_BEAT = 8;

  // ceil(65535/8) = 8192 needs 14 bits
  localparam int GRP_W = 14;

  // Status target w_tile*img_h*ngrp: 8 + 12 + 14 bits
  localparam int CNT_W = 34;

  // A beat holds 8 channels of dw bits: 8*dw/8 bytes.
  function automatic int beat_bytes(input int dw);
    return (CH_PER_BEAT * dw) / 8;
  endfunction

  function automatic logic [GRP_W-1:0] ceil_groups(input logic [CH_BITS-1:0] ch);
    logic [CH_BITS:0] sum;
    sum = {1'b0, ch} + 17'd7;
    return sum[CH_BITS:3];
  endfunction

endpackage

// File: rtl/ro_wr_sched_seg_addr_gen.sv
// ro_seg_addr_gen: walks tile -> line -> group -> pixel counters and keeps the
// DDR start address of the current segment using adds only.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   init            load base into all address registers, clear counters
//   beat            one beat of the current segment was transferred
//   base            job base byte address
//   seg_bytes       bytes per segment (img_w * beat bytes)
//   line_stride     bytes between consecutive lines
//   tile_stride     bytes between consecutive tiles
//   img_w, img_h, w_tile, ngrp   loop bounds (all non-zero while running)
//   seg_addr        start address of the current segment
//   last_beat       current beat is the last of its segment
//   last_seg        current segment is the final one of the job
import ro_wr_sched_pkg::*;

module ro_seg_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              beat,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] seg_bytes,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [ADDR_W-1:0] tile_stride,
  input  logic [11:0]       img_w,
  input  logic [11:0]       img_h,
  input  logic [7:0]        w_tile,
  input  logic [GRP_W-1:0]  ngrp,
  output logic [ADDR_W-1:0] seg_addr,
  output logic              last_beat,
  output logic              last_seg
);

  logic [7:0]        t_q, t_d;
  logic [11:0]       l_q, l_d;
  logic [GRP_W-1:0]  g_q, g_d;
  logic [11:0]       p_q, p_d;
  logic [ADDR_W-1:0] tile_addr_q, tile_addr_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;

  logic last_g;
  logic last_l;
  logic last_t;

  assign last_beat = (p_q == img_w - 12'd1);
  assign last_g    = (g_q == ngrp - GRP_W'(1));
  assign last_l    = (l_q == img_h - 12'd1);
  assign last_t    = (t_q == w_tile - 8'd1);
  assign last_seg  = last_g && last_l && last_t;
  assign seg_addr  = seg_addr_q;

  always_comb begin
    t_d         = t_q;
    l_d         = l_q;
    g_d         = g_q;
    p_d         = p_q;
    tile_addr_d = tile_addr_q;
    line_addr_d = line_addr_q;
    seg_addr_d  = seg_addr_q;
    if (init) begin
      t_d         = '0;
      l_d         = '0;
      g_d         = '0;
      p_d         = '0;
      tile_addr_d = base;
      line_addr_d = base;
      seg_addr_d  = base;
    end else if (beat) begin
      if (!last_beat) begin
        p_d = p_q + 12'd1;
      end else begin
        p_d = '0;
        if (!last_g) begin
          g_d        = g_q + GRP_W'(1);
          seg_addr_d = seg_addr_q + seg_bytes;
        end else if (!last_l) begin
          // Next line of the same tile: group 0 restarts at the new line base.
          g_d         = '0;
          l_d         = l_q + 12'd1;
          line_addr_d = line_addr_q + line_stride;
          seg_addr_d  = line_addr_q + line_stride;
        end else begin
          // Next tile: line 0, group 0 of the new tile base. After the final
          // segment these values are never used.
          g_d         = '0;
          l_d         = '0;
          t_d         = t_q + 8'd1;
          tile_addr_d = tile_addr_q + tile_stride;
          line_addr_d = tile_addr_q + tile_stride;
          seg_addr_d  = tile_addr_q + tile_stride;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q         <= '0;
      l_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      tile_addr_q <= '0;
      line_addr_q <= '0;
      seg_addr_q  <= '0;
    end else begin
      t_q         <= t_d;
      l_q         <= l_d;
      g_q         <= g_d;
      p_q         <= p_d;
      tile_addr_q <= tile_addr_d;
      line_addr_q <= line_addr_d;
      seg_addr_q  <= seg_addr_d;
    end
  end

endmodule

// File: rtl/ro_wr_sched.sv
// ro_wr_sched: write scheduler between the reorder stage and the DDR write
// DataMover. The reorder stream (8 channels per beat) is cut into segments of
// img_w beats, one per (tile, line, channel-group). For each segment one
// command (address, byte count) is issued, then the segment's beats are passed
// through with tlast on the final beat. Write statuses are counted; done
// pulses once all of them have arrived, err is sticky.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge. A source holds valid and its payload stable
// until that edge; ready may toggle freely and may depend combinationally on
// valid. s_sts_valid has no ready: each pulse is one status.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_config_valid/ready/data         three config words w0, w1, w2
//   ro_data/valid/ready               reorder beat input
//   m_axis_tdata/tvalid/tready/tlast  beat output to the DataMover
//   m_cmd_valid/ready/addr/btt        segment command to the DataMover
//   s_sts_valid, s_sts_okay           write status input
//   done                              one-cycle pulse when job is complete
//   err                               sticky error, cleared by the next w0
//   status_wr                         current FSM state code
import ro_wr_sched_pkg::*;

module ro_wr_sched #(
  parameter int DW     = 16,
  parameter int ADDR_W = 32,
  parameter int BTT_W  = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_config_valid,
  output logic              s_config_ready,
  input  logic [31:0]       s_config_data,
  input  logic [8*DW-1:0]   ro_data,
  input  logic              ro_valid,
  output logic              ro_ready,
  output logic [8*DW-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic [BTT_W-1:0]  m_cmd_btt,
  input  logic              s_sts_valid,
  input  logic              s_sts_okay,
  output logic              done,
  output logic              err,
  output logic [3:0]        status_wr
);

  localparam int BEAT_BYTES = beat_bytes(DW);

  wr_state_e         state_q, state_d;
  logic [1:0]        widx_q, widx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       cfg1_q, cfg1_d;
  logic [31:0]       cfg2_q, cfg2_d;
  logic [BTT_W-1:0]  seg_bytes_q, seg_bytes_d;
  logic [GRP_W-1:0]  ngrp_q, ngrp_d;
  logic [ADDR_W-1:0] line_stride_q, line_stride_d;
  logic [ADDR_W-1:0] tile_stride_q, tile_stride_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  sts_cnt_q, sts_cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  // Config fields decoded from the captured words
  logic [IMG_W_BITS-1:0]  img_w;
  logic [IMG_H_BITS-1:0]  img_h;
  logic [W_TILE_BITS-1:0] w_tile;
  logic [CH_BITS-1:0]     ch_per;
  logic [CH_BITS-1:0]     ch_tot;

  assign img_w  = cfg1_q[IMG_W_LSB  +: IMG_W_BITS];
  assign img_h  = cfg1_q[IMG_H_LSB  +: IMG_H_BITS];
  assign w_tile = cfg1_q[W_TILE_LSB +: W_TILE_BITS];
  assign ch_per = cfg2_q[CH_PER_LSB +: CH_BITS];
  assign ch_tot = cfg2_q[CH_TOT_LSB +: CH_BITS];

  // Job geometry; the products are only registered in PRE.
  logic [BTT_W-1:0]  seg_bytes_c;
  logic [ADDR_W-1:0] seg_ext_c;
  logic [GRP_W-1:0]  ngrp_c;
  logic [GRP_W-1:0]  tot_grp_c;
  logic              cfg_bad_c;

  assign seg_bytes_c = BTT_W'(img_w) * BTT_W'(BEAT_BYTES);
  assign seg_ext_c   = ADDR_W'(seg_bytes_c);
  assign ngrp_c      = ceil_groups(ch_per);
  assign tot_grp_c   = ceil_groups(ch_tot);
  assign cfg_bad_c   = (img_w == '0) || (img_h == '0) || (w_tile == '0) || (ch_per == '0);

  // Segment walker
  logic              gen_init;
  logic              gen_beat;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last_beat;
  logic              gen_last_seg;

  assign gen_beat = (state_q == ST_DATA) && ro_valid && m_axis_tready;

  ro_seg_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (gen_init),
    .beat        (gen_beat),
    .base        (base_q),
    .seg_bytes   (ADDR_W'(seg_bytes_q)),
    .line_stride (line_stride_q),
    .tile_stride (tile_stride_q),
    .img_w       (img_w),
    .img_h       (img_h),
    .w_tile      (w_tile),
    .ngrp        (ngrp_q),
    .seg_addr    (gen_addr),
    .last_beat   (gen_last_beat),
    .last_seg    (gen_last_seg)
  );

  // Data path is a zero-latency pass-through gated by the DATA state, so the
  // reorder stage is back-pressured (never dropped) everywhere else.
  assign s_config_ready = (state_q == ST_IDLE);
  assign m_cmd_valid    = (state_q == ST_CMD);
  assign m_cmd_addr     = gen_addr;
  assign m_cmd_btt      = seg_bytes_q;
  assign m_axis_tdata   = ro_data;
  assign m_axis_tvalid  = (state_q == ST_DATA) && ro_valid;
  assign ro_ready       = (state_q == ST_DATA) && m_axis_tready;
  assign m_axis_tlast   = (state_q == ST_DATA) && gen_last_beat;
  assign done           = done_q;
  assign err            = err_q;
  assign status_wr      = state_q;

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    base_d        = base_q;
    cfg1_d        = cfg1_q;
    cfg2_d        = cfg2_q;
    seg_bytes_d   = seg_bytes_q;
    ngrp_d        = ngrp_q;
    line_stride_d = line_stride_q;
    tile_stride_d = tile_stride_q;
    target_d      = target_q;
    sts_cnt_d     = sts_cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    gen_init      = 1'b0;

    // Statuses are counted in every active state, including the cycle of the
    // final beat; a bad status flags err but the job keeps running.
    if ((state_q != ST_IDLE) && s_sts_valid) begin
      sts_cnt_d = sts_cnt_q + CNT_W'(1);
      if (!s_sts_okay) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (s_config_valid) begin
          unique case (widx_q)
            2'd0: begin
              base_d = ADDR_W'(s_config_data);
              err_d  = 1'b0;
              widx_d = 2'd1;
            end
            2'd1: begin
              cfg1_d = s_config_data;
              widx_d = 2'd2;
            end
            default: begin
              cfg2_d    = s_config_data;
              widx_d    = 2'd0;
              sts_cnt_d = '0;
              state_d   = ST_PRE;
            end
          endcase
        end
      end

      ST_PRE: begin
        seg_bytes_d   = seg_bytes_c;
        ngrp_d        = ngrp_c;
        line_stride_d = ADDR_W'(tot_grp_c) * seg_ext_c;
        tile_stride_d = ADDR_W'(ngrp_c) * seg_ext_c;
        target_d      = CNT_W'(w_tile) * CNT_W'(img_h) * CNT_W'(ngrp_c);
        if (cfg_bad_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gen_init = 1'b1;
          state_d  = ST_CMD;
        end
      end

      ST_CMD: begin
        if (m_cmd_ready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (gen_beat && gen_last_beat) begin
          state_d = gen_last_seg ? ST_DRAIN : ST_CMD;
        end
      end

      ST_DRAIN: begin
        if (sts_cnt_q == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      widx_q        <= '0;
      base_q        <= '0;
      cfg1_q        <= '0;
      cfg2_q        <= '0;
      seg_bytes_q   <= '0;
      ngrp_q        <= '0;
      line_stride_q <= '0;
      tile_stride_q <= '0;
      target_q      <= '0;
      sts_cnt_q     <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      base_q        <= base_d;
      cfg1_q        <= cfg1_d;
      cfg2_q        <= cfg2_d;
      seg_bytes_q   <= seg_bytes_d;
      ngrp_q        <= ngrp_d;
      line_stride_q <= line_stride_d;
      tile_stride_q <= tile_stride_d;
      target_q      <= target_d;
      sts_cnt_q     <= sts_cnt_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_ro_wr_sched.sv
// Testbench for ro_wr_sched: drives config words, a reorder beat source, a
// DataMover command/data sink and a status return path, and compares the
// observed commands and beats with a loop-nest reference model.
module tb_ro_wr_sched;

  logic         clk;
  logic         rst_n;
  logic         s_config_valid;
  logic         s_config_ready;
  logic [31:0]  s_config_data;
  logic [127:0] ro_data;
  logic         ro_valid;
  logic         ro_ready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         m_cmd_valid;
  logic         m_cmd_ready;
  logic [31:0]  m_cmd_addr;
  logic [22:0]  m_cmd_btt;
  logic         s_sts_valid;
  logic         s_sts_okay;
  logic         done;
  logic         err;
  logic [3:0]   status_wr;

  ro_wr_sched #(.DW(16), .ADDR_W(32), .BTT_W(23)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_config_valid (s_config_valid),
    .s_config_ready (s_config_ready),
    .s_config_data  (s_config_data),
    .ro_data        (ro_data),
    .ro_valid       (ro_valid),
    .ro_ready       (ro_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_addr     (m_cmd_addr),
    .m_cmd_btt      (m_cmd_btt),
    .s_sts_valid    (s_sts_valid),
    .s_sts_okay     (s_sts_okay),
    .done           (done),
    .err            (err),
    .status_wr      (status_wr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0]  exp_addr_q[$];
  logic         exp_last_q[$];
  logic [127:0] src_q[$];
  logic [22:0]  exp_btt;

  task automatic build_model(input logic [31:0] base, input int iw, input int ih,
                             input int wt, input int chp, input int cht);
    int ngrp, seg, ls, ts;
    exp_addr_q.delete();
    exp_last_q.delete();
    src_q.delete();
    ngrp    = (chp + 7) / 8;
    seg     = iw * 2 * 8;        // 8 channels x 16 bits = 16 bytes per pixel
    ls      = ((cht + 7) / 8) * seg;
    ts      = ngrp * seg;
    exp_btt = 23'(seg);
    for (int t = 0; t < wt; t++)
      for (int l = 0; l < ih; l++)
        for (int g = 0; g < ngrp; g++) begin
          exp_addr_q.push_back(base + 32'(t * ts + l * ls + g * seg));
          for (int p = 0; p < iw; p++) begin
            exp_last_q.push_back(p == iw - 1);
            src_q.push_back({$urandom, $urandom, $urandom, $urandom});
          end
        end
  endtask

  function automatic logic [31:0] mk_w1(input int iw, input int ih, input int wt);
    return {8'(wt), 12'(ih), 12'(iw)};
  endfunction

  function automatic logic [31:0] mk_w2(input int chp, input int cht);
    return {16'(cht), 16'(chp)};
  endfunction

  // ---------------- observed results ----------------
  logic [31:0]  obs_addr_q[$];
  logic [22:0]  obs_btt_q[$];
  logic [127:0] obs_data_q[$];
  logic         obs_last_q[$];
  int           done_cnt;
  int           cmd_valid_cycles;
  int           stall_viol;
  logic         err_at_done;
  bit           timed_out;

  // ---------------- driver ----------------
  task automatic run_job(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input bit rnd, input int cmd_hold, input int bad_sts,
                         input int abort_beats, input int max_cycles);
    logic [31:0] cw[3];
    int cyc, pend, hold, sent, sts_idx, post;
    bit have_prev;
    logic [31:0] prev_addr;
    obs_addr_q.delete();
    obs_btt_q.delete();
    obs_data_q.delete();
    obs_last_q.delete();
    done_cnt = 0; cmd_valid_cycles = 0; stall_viol = 0; err_at_done = 1'bx; timed_out = 0;
    cyc = 0; pend = 0; hold = 0; sent = 0; sts_idx = 0; post = 0; have_prev = 0; prev_addr = '0;
    cw[0] = w0; cw[1] = w1; cw[2] = w2;
    for (int i = 0; i < 3; i++) begin
      int k;
      @(negedge clk);
      s_config_valid = 1'b1;
      s_config_data  = cw[i];
      k = 0;
      while (!s_config_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) timed_out = 1;
      @(posedge clk);
    end
    while (cyc < max_cycles) begin
      @(negedge clk);
      s_config_valid = 1'b0;
      m_cmd_ready    = (hold < cmd_hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axis_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ro_valid       = (sent < src_q.size()) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      ro_data        = (sent < src_q.size()) ? src_q[sent] : '0;
      s_sts_valid    = (pend > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      s_sts_okay     = (sts_idx != bad_sts);
      #1;
      if (m_cmd_valid) begin
        cmd_valid_cycles++;
        if (ro_ready || m_axis_tvalid) stall_viol++;
        if (have_prev && m_cmd_addr !== prev_addr) stall_viol++;
        if (m_cmd_ready) begin
          obs_addr_q.push_back(m_cmd_addr);
          obs_btt_q.push_back(m_cmd_btt);
          have_prev = 0;
        end else begin
          hold++;
          prev_addr = m_cmd_addr;
          have_prev = 1;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_data_q.push_back(m_axis_tdata);
        obs_last_q.push_back(m_axis_tlast);
        if (m_axis_tlast) pend++;
      end
      if (ro_valid && ro_ready) sent++;
      if (s_sts_valid) begin
        pend--;
        sts_idx++;
      end
      if (done) begin
        done_cnt++;
        err_at_done = err;
      end
      if (done_cnt > 0) post++;
      cyc++;
      @(posedge clk);
      if (post >= 4) break;
      if (abort_beats > 0 && obs_data_q.size() >= abort_beats) break;
    end
    if (cyc >= max_cycles) timed_out = 1;
    @(negedge clk);
    s_config_valid = 1'b0;
    ro_valid       = 1'b0;
    s_sts_valid    = 1'b0;
    s_sts_okay     = 1'b1;
    m_cmd_ready    = 1'b0;
    m_axis_tready  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    ro_valid = 1'b1; m_axis_tready = 1'b1; m_cmd_ready = 1'b1;
    #1;
    n_vec++; if (s_config_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b exp 1", s_config_ready); end
    n_vec++; if (m_cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid got %b exp 0", m_cmd_valid); end
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    n_vec++; if (ro_ready !== 1'b0) begin n_err++; $display("FAIL reset_ro_ready got %b exp 0", ro_ready); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
    n_vec++; if (status_wr !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", status_wr); end
    ro_valid = 1'b0; m_axis_tready = 1'b0; m_cmd_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] fixed[4];
    fixed[0] = 32'h1000_0000; fixed[1] = 32'h1000_0040;
    fixed[2] = 32'h1000_0080; fixed[3] = 32'h1000_00C0;
    build_model(32'h1000_0000, 4, 2, 1, 16, 16);
    run_job(32'h1000_0000, mk_w1(4, 2, 1), mk_w2(16, 16), 0, 0, -1, 0, 2000);
    n_vec++; if (obs_addr_q.size() != 4) begin n_err++; $display("FAIL basic_ncmd got %0d exp 4", obs_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_addr_q.size() || obs_addr_q[i] !== fixed[i] || obs_btt_q[i] !== 23'd64) begin
        n_err++; $display("FAIL basic_cmd%0d got %h/%0d exp %h/64", i,
                          (i < obs_addr_q.size()) ? obs_addr_q[i] : 32'hx,
                          (i < obs_btt_q.size()) ? obs_btt_q[i] : 23'hx, fixed[i]);
      end
    end
    n_vec++; if (obs_data_q.size() != 16) begin n_err++; $display("FAIL basic_nbeats got %0d exp 16", obs_data_q.size()); end
    foreach (exp_last_q[i]) begin
      n_vec++;
      if (i >= obs_data_q.size() || obs_data_q[i] !== src_q[i] || obs_last_q[i] !== exp_last_q[i]) begin
        n_err++; $display("FAIL basic_beat%0d got last %b exp last %b", i,
                          (i < obs_last_q.size()) ? obs_last_q[i] : 1'bx, exp_last_q[i]);
      end
    end
    n_vec++; if (done_cnt != 1 || timed_out) begin n_err++; $display("FAIL basic_done got %0d pulses timeout %0d exp 1", done_cnt, timed_out); end
    n_vec++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL basic_err got %b exp 0", err_at_done); end
  endtask

  task automatic test_two_tiles();
    build_model(32'h1000_0000, 4, 2, 2, 16, 32);
    run_job(32'h1000_0000, mk_w1(4, 2, 2), mk_w2(16, 32), 0, 0, -1, 0, 2000);
    n_vec++; if (obs_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL tiles_ncmd got %0d exp %0d", obs_addr_q.size(), exp_addr_q.size()); end
    // Tile 1, line 0, group 0 is the fifth command; line 1 of tile 0 sits one line stride up.
    n_vec++; if (obs_addr_q.size() < 5 || obs_addr_q[4] !== 32'h1000_0080) begin n_err++; $display("FAIL tiles_t1_addr got %h exp 10000080", (obs_addr_q.size() >= 5) ? obs_addr_q[4] : 32'hx); end
    n_vec++; if (obs_addr_q.size() < 3 || obs_addr_q[2] !== 32'h1000_0100) begin n_err++; $display("FAIL tiles_line_stride got %h exp 10000100", (obs_addr_q.size() >= 3) ? obs_addr_q[2] : 32'hx); end
    foreach (exp_addr_q[i]) begin
      n_vec++;
      if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i]) begin
        n_err++; $display("FAIL tiles_cmd%0d got %h exp %h", i, (i < obs_addr_q.size()) ? obs_addr_q[i] : 32'hx, exp_addr_q[i]);
      end
    end
    n_vec++; if (obs_data_q.size() != exp_last_q.size() || done_cnt != 1) begin n_err++; $display("FAIL tiles_beats got %0d/%0d exp %0d/1", obs_data_q.size(), done_cnt, exp_last_q.size()); end
  endtask

  task automatic test_cmd_stall();
    build_model(32'h2000_0000, 4, 2, 1, 16, 16);
    run_job(32'h2000_0000, mk_w1(4, 2, 1), mk_w2(16, 16), 0, 10, -1, 0, 2000);
    n_vec++; if (stall_viol != 0) begin n_err++; $display("FAIL stall_violations got %0d exp 0", stall_viol); end
    n_vec++; if (cmd_valid_cycles < 14) begin n_err++; $display("FAIL stall_cmd_cycles got %0d exp >= 14", cmd_valid_cycles); end
    n_vec++; if (obs_addr_q.size() < 1 || obs_addr_q[0] !== 32'h2000_0000) begin n_err++; $display("FAIL stall_first_addr got %h exp 20000000", (obs_addr_q.size() > 0) ? obs_addr_q[0] : 32'hx); end
    n_vec++; if (obs_data_q.size() != src_q.size()) begin n_err++; $display("FAIL stall_nbeats got %0d exp %0d", obs_data_q.size(), src_q.size()); end
    foreach (src_q[i]) begin
      n_vec++;
      if (i >= obs_data_q.size() || obs_data_q[i] !== src_q[i]) begin
        n_err++; $display("FAIL stall_beat%0d got %h exp %h", i, (i < obs_data_q.size()) ? obs_data_q[i] : 128'hx, src_q[i]);
      end
    end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_random_backpressure();
    for (int r = 0; r < 4; r++) begin
      int iw, ih, wt, chp, cht;
      logic [31:0] base;
      iw   = $urandom_range(1, 6);
      ih   = $urandom_range(1, 3);
      wt   = $urandom_range(1, 2);
      chp  = $urandom_range(1, 20);
      cht  = chp + $urandom_range(0, 20);
      base = (r == 3) ? 32'hFFFF_FF00 : $urandom;   // last job wraps the address space
      build_model(base, iw, ih, wt, chp, cht);
      run_job(base, mk_w1(iw, ih, wt), mk_w2(chp, cht), 1, 0, -1, 0, 20000);
      n_vec++; if (obs_addr_q.size() != exp_addr_q.size() || stall_viol != 0) begin n_err++; $display("FAIL rand%0d_ncmd got %0d viol %0d exp %0d", r, obs_addr_q.size(), stall_viol, exp_addr_q.size()); end
      foreach (exp_addr_q[i]) begin
        n_vec++;
        if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i] || obs_btt_q[i] !== exp_btt) begin
          n_err++; $display("FAIL rand%0d_cmd%0d got %h exp %h btt %0d", r, i, (i < obs_addr_q.size()) ? obs_addr_q[i] : 32'hx, exp_addr_q[i], exp_btt);
        end
      end
      n_vec++; if (obs_data_q.size() != src_q.size()) begin n_err++; $display("FAIL rand%0d_nbeats got %0d exp %0d", r, obs_data_q.size(), src_q.size()); end
      foreach (src_q[i]) begin
        n_vec++;
        if (i >= obs_data_q.size() || obs_data_q[i] !== src_q[i] || obs_last_q[i] !== exp_last_q[i]) begin
          n_err++; $display("FAIL rand%0d_beat%0d got last %b exp last %b", r, i, (i < obs_last_q.size()) ? obs_last_q[i] : 1'bx, exp_last_q[i]);
        end
      end
      n_vec++; if (done_cnt != 1 || err_at_done !== 1'b0) begin n_err++; $display("FAIL rand%0d_done got %0d err %b exp 1 err 0", r, done_cnt, err_at_done); end
    end
  endtask

  task automatic test_bad_config();
    build_model(32'h3000_0000, 0, 2, 1, 16, 16);
    run_job(32'h3000_0000, mk_w1(0, 2, 1), mk_w2(16, 16), 0, 0, -1, 0, 20);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badcfg_err got %b exp 1", err); end
    n_vec++; if (cmd_valid_cycles != 0) begin n_err++; $display("FAIL badcfg_cmd_cycles got %0d exp 0", cmd_valid_cycles); end
    n_vec++; if (status_wr !== 4'd0 || done_cnt != 0) begin n_err++; $display("FAIL badcfg_state got %0d done %0d exp 0/0", status_wr, done_cnt); end
    // The next valid config clears err and runs normally.
    build_model(32'h3000_0000, 2, 1, 1, 8, 8);
    run_job(32'h3000_0000, mk_w1(2, 1, 1), mk_w2(8, 8), 0, 0, -1, 0, 2000);
    n_vec++; if (err_at_done !== 1'b0 || done_cnt != 1) begin n_err++; $display("FAIL badcfg_recover got err %b done %0d exp 0/1", err_at_done, done_cnt); end
    n_vec++; if (obs_addr_q.size() != 1 || obs_data_q.size() != 2) begin n_err++; $display("FAIL badcfg_recover_stream got %0d cmds %0d beats exp 1/2", obs_addr_q.size(), obs_data_q.size()); end
  endtask

  task automatic test_bad_status();
    build_model(32'h1000_0000, 4, 2, 1, 16, 16);
    run_job(32'h1000_0000, mk_w1(4, 2, 1), mk_w2(16, 16), 0, 0, 1, 0, 2000);
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL badsts_done got %0d exp 1", done_cnt); end
    n_vec++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL badsts_err_at_done got %b exp 1", err_at_done); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badsts_err_sticky got %b exp 1", err); end
    n_vec++; if (obs_data_q.size() != 16) begin n_err++; $display("FAIL badsts_nbeats got %0d exp 16", obs_data_q.size()); end
  endtask

  task automatic test_reset_mid_data();
    build_model(32'h4000_0000, 4, 2, 1, 16, 16);
    run_job(32'h4000_0000, mk_w1(4, 2, 1), mk_w2(16, 16), 0, 0, -1, 6, 2000);
    ro_valid = 1'b1; m_axis_tready = 1'b1; m_cmd_ready = 1'b1; s_sts_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++; if (status_wr !== 4'd0 || s_config_ready !== 1'b1) begin n_err++; $display("FAIL midrst_state got %0d rdy %b exp 0/1", status_wr, s_config_ready); end
    n_vec++; if (m_axis_tvalid !== 1'b0 || ro_ready !== 1'b0 || m_cmd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_hs got tv %b rr %b cv %b exp 0", m_axis_tvalid, ro_ready, m_cmd_valid); end
    n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL midrst_flags got done %b err %b exp 0", done, err); end
    @(negedge clk);
    ro_valid = 1'b0; m_axis_tready = 1'b0; m_cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    build_model(32'h4000_0000, 4, 2, 1, 16, 16);
    run_job(32'h4000_0000, mk_w1(4, 2, 1), mk_w2(16, 16), 1, 0, -1, 0, 5000);
    n_vec++; if (done_cnt != 1 || obs_data_q.size() != 16 || obs_addr_q.size() != 4) begin n_err++; $display("FAIL midrst_recover got done %0d beats %0d cmds %0d exp 1/16/4", done_cnt, obs_data_q.size(), obs_addr_q.size()); end
    n_vec++; if (obs_addr_q.size() < 1 || obs_addr_q[0] !== 32'h4000_0000) begin n_err++; $display("FAIL midrst_first_addr got %h exp 40000000", (obs_addr_q.size() > 0) ? obs_addr_q[0] : 32'hx); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    s_config_valid = 1'b0; s_config_data = '0;
    ro_data = '0; ro_valid = 1'b0;
    m_axis_tready = 1'b0; m_cmd_ready = 1'b0;
    s_sts_valid = 1'b0; s_sts_okay = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_two_tiles();
    test_cmd_stall();
    test_random_backpressure();
    test_bad_config();
    test_bad_status();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
